// File: rtl/rvvi_trace_packer.sv
// rvvi_trace_packer: buffers parsed trace records in per-hart FIFOs and
// drains up to NRET records per hart per cycle into registered RVVI lanes.
module rvvi_trace_packer #(
    parameter  int XLEN  = 64,
    parameter  int NHART = 1,
    parameter  int NRET  = 2,
    parameter  int DEPTH = 8,
    localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [HW-1:0]               in_hart,
    input  logic [31:0]                 in_insn,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [1:0]                  in_mode,
    input  logic                        in_trap,
    input  logic [4:0]                  in_rd,
    input  logic                        in_rd_we,
    input  logic [XLEN-1:0]             in_rd_val,
    input  logic                        in_last,
    input  logic                        drain_en,
    output logic [NHART*NRET-1:0]       out_valid,
    output logic [NHART*NRET*64-1:0]    out_order,
    output logic [NHART*NRET*32-1:0]    out_insn,
    output logic [NHART*NRET*XLEN-1:0]  out_pc,
    output logic [NHART*NRET*2-1:0]     out_mode,
    output logic [NHART*NRET-1:0]       out_trap,
    output logic [NHART*NRET*32-1:0]    out_x_wb,
    output logic [NHART*NRET*XLEN-1:0]  out_x_wdata,
    output logic                        done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NL = NHART * NRET;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic [1:0]      mode;
        logic            trap;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] rd_val;
    } rec_t;

    rec_t            mem       [NHART][DEPTH];
    logic [PW-1:0]   rd_ptr    [NHART];
    logic [PW-1:0]   wr_ptr    [NHART];
    logic [CW-1:0]   count     [NHART];
    logic [63:0]     order_ctr [NHART];
    logic            last_seen;

    rec_t            rec_in;
    rec_t            lane_rec  [NL];
    logic [NL-1:0]   lane_take;
    logic [NL-1:0]   ovalid_nxt;
    logic [CW-1:0]   pop_k     [NHART];
    logic [CW-1:0]   cnt_nxt   [NHART];
    logic [NHART-1:0] push_h;
    logic [CW-1:0]   sel_count;
    logic            hart_ok;
    logic            accept;
    logic            all_empty;
    logic            last_seen_nxt;
    logic            done_nxt;

    // Input handshake, head-of-FIFO lane selection and next-state bookkeeping
    always_comb begin
        logic          stop;
        logic [CW-1:0] k;
        int unsigned   l;
        rec_in    = '{insn: in_insn, pc: in_pc, mode: in_mode, trap: in_trap,
                      rd: in_rd, rd_we: in_rd_we, rd_val: in_rd_val};
        hart_ok   = 32'(in_hart) < NHART;
        sel_count = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            if (in_hart == HW'(h)) sel_count = count[h];
        end
        // Out-of-range harts always handshake so the parser never stalls on them
        in_ready  = reset_n && !last_seen && (!hart_ok || sel_count < CW'(DEPTH));
        accept    = in_valid && in_ready;
        lane_take = '0;
        all_empty = 1'b1;
        for (int unsigned h = 0; h < NHART; h++) begin
            stop = 1'b0;
            k    = '0;
            for (int unsigned r = 0; r < NRET; r++) begin
                l           = h * NRET + r;
                lane_rec[l] = mem[h][rd_ptr[h] + PW'(r)];
                // A trapping record closes the group; later lanes wait a cycle
                if (!stop && 32'(count[h]) > r) begin
                    lane_take[l] = 1'b1;
                    k            = k + CW'(1);
                    if (lane_rec[l].trap) stop = 1'b1;
                end
            end
            pop_k[h]   = drain_en ? k : '0;
            push_h[h]  = accept && hart_ok && (in_hart == HW'(h));
            cnt_nxt[h] = count[h] + CW'(push_h[h]) - pop_k[h];
            if (cnt_nxt[h] != '0) all_empty = 1'b0;
        end
        ovalid_nxt    = drain_en ? lane_take : '0;
        last_seen_nxt = last_seen || (accept && in_last);
        done_nxt      = done || (last_seen_nxt && all_empty && (ovalid_nxt == '0));
    end

    // FIFO payload storage (no reset needed; occupancy lives in count)
    always_ff @(posedge clk) begin
        for (int unsigned h = 0; h < NHART; h++) begin
            if (push_h[h]) mem[h][wr_ptr[h]] <= rec_in;
        end
    end

    // Pointers, counters, registered retire lanes and completion flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_seen   <= 1'b0;
            done        <= 1'b0;
            out_valid   <= '0;
            out_order   <= '0;
            out_insn    <= '0;
            out_pc      <= '0;
            out_mode    <= '0;
            out_trap    <= '0;
            out_x_wb    <= '0;
            out_x_wdata <= '0;
            for (int unsigned h = 0; h < NHART; h++) begin
                rd_ptr[h]    <= '0;
                wr_ptr[h]    <= '0;
                count[h]     <= '0;
                order_ctr[h] <= '0;
            end
        end else begin
            last_seen <= last_seen_nxt;
            done      <= done_nxt;
            out_valid <= ovalid_nxt;
            for (int unsigned h = 0; h < NHART; h++) begin
                count[h]     <= cnt_nxt[h];
                rd_ptr[h]    <= rd_ptr[h] + PW'(pop_k[h]);
                order_ctr[h] <= order_ctr[h] + 64'(pop_k[h]);
                if (push_h[h]) wr_ptr[h] <= wr_ptr[h] + PW'(1);
                for (int unsigned r = 0; r < NRET; r++) begin
                    if (ovalid_nxt[h*NRET+r]) begin
                        out_order[(h*NRET+r)*64 +: 64]     <= order_ctr[h] + 64'(r) + 64'd1;
                        out_insn[(h*NRET+r)*32 +: 32]      <= lane_rec[h*NRET+r].insn;
                        out_pc[(h*NRET+r)*XLEN +: XLEN]    <= lane_rec[h*NRET+r].pc;
                        out_mode[(h*NRET+r)*2 +: 2]        <= lane_rec[h*NRET+r].mode;
                        out_trap[h*NRET+r]                 <= lane_rec[h*NRET+r].trap;
                        if (lane_rec[h*NRET+r].rd_we && lane_rec[h*NRET+r].rd != 5'd0) begin
                            out_x_wb[(h*NRET+r)*32 +: 32]      <= 32'd1 << lane_rec[h*NRET+r].rd;
                            out_x_wdata[(h*NRET+r)*XLEN +: XLEN] <= lane_rec[h*NRET+r].rd_val;
                        end else begin
                            out_x_wb[(h*NRET+r)*32 +: 32]      <= '0;
                            out_x_wdata[(h*NRET+r)*XLEN +: XLEN] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/rvvi_trace_packer.md
# rvvi_trace_packer

Parametrised multi-hart, multi-retire trace replay stage for the coverage testbench. It accepts one parsed trace record per cycle over a valid/ready handshake and buffers records in a per-hart FIFO. Each cycle it drains up to NRET records per hart into registered RVVI-shaped retire lanes, maintaining a per-hart retirement order counter. It sits between the trace-file parser and the `rvviTrace` interface, replacing the single-lane, one-record-per-clock direct drive.

## Interface

Parameters:
- XLEN, 64, integer register / PC width.
- NHART, 1, number of harts (channels).
- NRET, 2, retire lanes per hart per cycle (≥1).
- DEPTH, 8, FIFO entries per hart (power of 2, ≥2).

Ports. HW = (NHART>1 ? $clog2(NHART) : 1). Lane vectors are flattened with lane index l = h*NRET + r.
- clk, in, 1, clock.
- reset_n, in, 1, reset, asynchronous assert, active-low.
- in_valid, in, 1, record present.
- in_ready, out, 1, record accepted when in_valid & in_ready at posedge.
- in_hart, in, HW, target hart; values ≥NHART are dropped but still handshake.
- in_insn, in, 32, instruction.
- in_pc, in, XLEN, PC.
- in_mode, in, 2, privilege mode.
- in_trap, in, 1, record traps.
- in_rd, in, 5, destination register.
- in_rd_we, in, 1, destination write valid.
- in_rd_val, in, XLEN, destination write data.
- in_last, in, 1, final record of trace.
- drain_en, in, 1, consumer accepts a retire group this cycle.
- out_valid, out, NHART*NRET, lane valid.
- out_order, out, NHART*NRET*64, retirement order.
- out_insn, out, NHART*NRET*32, instruction.
- out_pc, out, NHART*NRET*XLEN, PC.
- out_mode, out, NHART*NRET*2, privilege mode.
- out_trap, out, NHART*NRET, trap flag.
- out_x_wb, out, NHART*NRET*32, one-hot x register write mask.
- out_x_wdata, out, NHART*NRET*XLEN, write data.
- done, out, 1, trace fully replayed.

## Operation

- Reset (reset_n=0): all FIFOs empty, order counters 0, out_valid 0, all out data 0, done 0, a sticky `last_seen` flag 0, in_ready 0.
- in_ready = reset_n & !last_seen & (count[in_hart] < DEPTH). It is combinational on in_hart. A pop in the same cycle does not free a slot for a push; there is no bypass.
- Accepting a record with in_last=1 sets last_seen. in_ready then stays 0 until reset.
- Drain, per hart, on each posedge with drain_en=1:
  - Let k = number of head entries taken: contiguous from the FIFO head, at most min(NRET, count).
  - Stop after the first entry with trap=1; that entry is included and later lanes stay invalid this cycle.
  - Lanes 0..k-1 load entries in FIFO order with out_valid=1. Lanes ≥k get out_valid=0, and their data hold previous values.
  - Lane r order = order_ctr + r + 1. Then order_ctr += k. The first record per hart has order 1. The counter wraps modulo 2^64.
- drain_en=0: out_valid is all 0 next cycle, FIFOs and counters are unchanged, and out data hold.
- out_x_wb lane = (rd_we & rd≠0) ? (1<<rd) : 0. out_x_wdata = rd_val when the mask is nonzero, else 0. Writes to x0 are suppressed.
- A push and pop on the same hart in one cycle: count' = count + 1 − k. FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
- done is registered. It is set on the posedge after which last_seen=1, all FIFOs are empty and out_valid is 0. It stays sticky until reset.

## Timing

- Minimum latency: a record accepted at edge n can appear on out_* after edge n+1, provided drain_en=1 at n+1.
- All out_* and done are flops. in_ready is the only combinational output.
- Throughput: 1 record in per cycle; up to NRET out per hart per cycle.
- Reset is asynchronous and clears state immediately mid-operation, including in-flight lanes. The first post-reset accept is possible on the first edge with reset_n=1.

## Test plan

- **Reset:** hold reset_n=0 with in_valid=1 → in_ready=0, out_valid=0, done=0; release → in_ready=1 and no accept occurred.
- **Packing** (NRET=2): push 3 non-trap records on hart 0 (PCs 0x1000/0x1004/0x1008) with drain_en=1 → first group lanes 0,1 at orders 1,2; next group lane 0 with PC 0x1008, order 3, lane 1 invalid.
- **Trap split:** push A(trap=1), then B → group 1: lane 0 = A, order 1, lane 1 invalid; group 2: lane 0 = B, order 2.
- **Full:** DEPTH=8, drain_en=0, offer 9 records → 8 accepted, in_ready=0 on the 9th. Raise drain_en while offering → no accept in that pop cycle; accept on the following cycle.
- **Multi-hart** (NHART=2): interleave hart0/hart1 records → per-hart orders independent (each starts at 1), and FIFO order is preserved per hart.
- **x0 and completion:** record rd=0, rd_we=1, rd_val=0xdead with in_last=1 → out_x_wb=0 and out_x_wdata=0; in_ready drops after the accept; done=1 one cycle after the lane retires. Assert reset_n low → done=0 immediately.
